// File: rtl/dmem_responder_if.sv
// Load/store bus between a processor data port and the dmem_responder.
// The master side issues requests and consumes responses; the slave side is the memory.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_funct3, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_funct3, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store with RISC-V B/H/W sizing,
// a fixed request-to-response latency and a local word array as backing store.
module dmem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_WAIT = 2'b01;
   localparam logic [1:0] ST_RESP = 2'b10;

   // LATENCY==1 skips WAIT entirely; otherwise WAIT lasts LATENCY-1 cycles
   localparam logic [1:0] ST_AFTER_ACCEPT = (LATENCY == 1) ? ST_RESP : ST_WAIT;
   localparam int         CW              = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam int         WAIT_CNT        = (LATENCY > 1) ? (LATENCY - 2) : 0;
   localparam int         DEPTH           = 1 << ADDR_WIDTH;

   logic [31:0]           mem [DEPTH];

   logic [1:0]            state_r;
   logic [CW-1:0]         cnt_r;
   logic                  write_r;
   logic [31:0]           addr_r;
   logic [31:0]           wdata_r;
   logic [2:0]            funct3_r;
   logic                  req_ready_r;
   logic                  resp_valid_r;
   logic [31:0]           resp_rdata_r;
   logic                  resp_err_r;

   logic [1:0]            state_nxt_s;
   logic                  accept_s;
   logic                  handshake_s;
   logic                  enter_resp_s;
   logic                  op_write_s;
   logic [31:0]           op_addr_s;
   logic [31:0]           op_wdata_s;
   logic [2:0]            op_funct3_s;
   logic                  op_err_s;
   logic                  do_write_s;
   logic [ADDR_WIDTH-1:0] word_idx_s;
   logic [1:0]            lane_s;
   logic [3:0]            be_s;
   logic [31:0]           wlane_s;

   function automatic logic req_error(input logic wr, input logic [31:0] a, input logic [2:0] f3);
      logic oor;
      logic ill;
      logic mis;
      oor = (a >> (ADDR_WIDTH + 2)) != 32'd0;
      case (f3)
         3'b011, 3'b110, 3'b111: ill = 1'b1;
         default:                ill = wr & f3[2];
      endcase
      case (f3[1:0])
         2'b01:   mis = a[0];
         2'b10:   mis = (a[1:0] != 2'b00);
         default: mis = 1'b0;
      endcase
      return oor | ill | mis;
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
      case (f3[1:0])
         2'b00:   return 4'b0001 << lane;
         2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
         2'b10:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Replicate the low byte/half so every candidate lane carries the store data
   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b010:  return word;
         3'b100:  return {24'd0, sh[7:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return 32'd0;
      endcase
   endfunction

   // Operand select: live bus fields on the accept edge, latched copy afterwards
   always_comb begin
      op_write_s  = write_r;
      op_addr_s   = addr_r;
      op_wdata_s  = wdata_r;
      op_funct3_s = funct3_r;
      if (state_r == ST_IDLE) begin
         op_write_s  = bus.req_write;
         op_addr_s   = bus.req_addr;
         op_wdata_s  = bus.req_wdata;
         op_funct3_s = bus.req_funct3;
      end else begin
         op_write_s  = write_r;
         op_addr_s   = addr_r;
         op_wdata_s  = wdata_r;
         op_funct3_s = funct3_r;
      end
   end

   // Next-state decode for IDLE -> WAIT -> RESP -> IDLE
   always_comb begin
      state_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (bus.req_valid) begin
               state_nxt_s = ST_AFTER_ACCEPT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   assign accept_s     = (state_r == ST_IDLE) && bus.req_valid;
   assign handshake_s  = (state_r == ST_RESP) && bus.resp_ready;
   assign enter_resp_s = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
   assign op_err_s     = req_error(op_write_s, op_addr_s, op_funct3_s);
   assign do_write_s   = enter_resp_s && op_write_s && !op_err_s && !reset;
   assign word_idx_s   = op_addr_s[ADDR_WIDTH+1:2];
   assign lane_s       = op_addr_s[1:0];
   assign be_s         = byte_en(op_funct3_s, lane_s);
   assign wlane_s      = store_lanes(op_funct3_s, op_wdata_s);

   // Control state, request latch and registered response outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         cnt_r        <= {CW{1'b0}};
         write_r      <= 1'b0;
         addr_r       <= 32'd0;
         wdata_r      <= 32'd0;
         funct3_r     <= 3'd0;
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'd0;
         resp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         req_ready_r <= (state_nxt_s == ST_IDLE);
         if (accept_s) begin
            write_r  <= bus.req_write;
            addr_r   <= bus.req_addr;
            wdata_r  <= bus.req_wdata;
            funct3_r <= bus.req_funct3;
            cnt_r    <= CW'(WAIT_CNT);
         end else if ((state_r == ST_WAIT) && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - CW'(1);
         end
         if (enter_resp_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= op_err_s;
            resp_rdata_r <= (op_err_s || op_write_s) ? 32'd0
                                                     : load_extract(op_funct3_s, lane_s, mem[word_idx_s]);
         end else if (handshake_s) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
         end
      end
   end

   // Backing store: byte-lane write on the RESP-entry edge; contents survive reset
   always_ff @(posedge clk) begin
      if (do_write_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem[word_idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
            end
         end
      end
   end

   assign bus.req_ready  = req_ready_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_rdata = resp_rdata_r;
   assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) share one stimulus stream and are
// checked against a byte-addressed reference memory model.
module tb_dmem_responder;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   errors;
   int   checks;

   dmem_responder_if ia ();
   dmem_responder_if ib ();

   assign ib.req_valid  = ia.req_valid;
   assign ib.req_write  = ia.req_write;
   assign ib.req_addr   = ia.req_addr;
   assign ib.req_wdata  = ia.req_wdata;
   assign ib.req_funct3 = ia.req_funct3;
   assign ib.resp_ready = ia.resp_ready;

   dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
   dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

   logic [7:0] mem0 [logic [31:0]];
   logic [7:0] mem1 [logic [31:0]];
   exp_t       q0 [$];
   exp_t       q1 [$];
   int         acc [2];
   bit         prev_v [2];
   bit         hs_prev [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] get_byte(input int d, input logic [31:0] a);
      if (d == 0) return mem0.exists(a) ? mem0[a] : 8'h00;
      else        return mem1.exists(a) ? mem1[a] : 8'h00;
   endfunction

   function automatic void put_byte(input int d, input logic [31:0] a, input logic [7:0] b);
      if (d == 0) mem0[a] = b;
      else        mem1[a] = b;
   endfunction

   // Reference: byte-addressed memory, little-endian, applied when the request is issued
   function automatic exp_t model(input int d, input bit wr, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [2:0] f3);
      exp_t        e;
      int          size;
      logic [31:0] v;
      size   = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
      e.err  = (a >= 32'h0000_1000) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
               (wr && (f3 >= 3'd4)) || ((a % 32'(size)) != 32'd0);
      e.rdata = 32'd0;
      if (!e.err) begin
         if (wr) begin
            for (int k = 0; k < size; k++) put_byte(d, a + 32'(k), wd[8*k +: 8]);
         end else begin
            v = 32'd0;
            for (int k = 0; k < size; k++) v = v | (32'(get_byte(d, a + 32'(k))) << (8*k));
            if (!f3[2] && (size < 4) && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            e.rdata = v;
         end
      end
      return e;
   endfunction

   task automatic mon(input int d, input logic rv, input logic rr, input logic [31:0] rd,
                      input logic re, input logic qv, input logic qr);
      exp_t e;
      bit   has;
      if (reset) begin
         prev_v[d]  = 1'b0;
         hs_prev[d] = 1'b0;
      end else begin
         if (hs_prev[d]) chk($sformatf("ready_after_hs%0d", d), {31'd0, qr}, 32'd1);
         if (qv && qr) acc[d] = cyc;
         if (rv) begin
            if (!prev_v[d]) chk($sformatf("latency%0d", d), cyc - acc[d], (d == 0) ? 2 : 1);
            chk($sformatf("ready_low_in_resp%0d", d), {31'd0, qr}, 32'd0);
            has = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!has) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp%0d: got rdata %h err %b expected no response", d, rd, re);
            end else begin
               e = (d == 0) ? q0[0] : q1[0];
               chk($sformatf("rdata%0d", d), rd, e.rdata);
               chk($sformatf("err%0d", d), {31'd0, re}, {31'd0, e.err});
               if (rr) begin
                  if (d == 0) void'(q0.pop_front());
                  else        void'(q1.pop_front());
               end
            end
         end
         prev_v[d]  = rv && !rr;
         hs_prev[d] = rv && rr;
      end
   endtask

   // Monitor: compare whatever either DUT presents against the scoreboard head
   always @(negedge clk) begin
      mon(0, ia.resp_valid, ia.resp_ready, ia.resp_rdata, ia.resp_err, ia.req_valid, ia.req_ready);
      mon(1, ib.resp_valid, ib.resp_ready, ib.resp_rdata, ib.resp_err, ib.req_valid, ib.req_ready);
   end

   task automatic wait_ready();
      int guard = 0;
      while (!(ia.req_ready && ib.req_ready) && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         errors++;
         $display("FAIL timeout_ready: got req_ready %b/%b expected 1/1", ia.req_ready, ib.req_ready);
      end
   endtask

   task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input int stall);
      int guard;
      wait_ready();
      q0.push_back(model(0, wr, a, wd, f3));
      q1.push_back(model(1, wr, a, wd, f3));
      ia.resp_ready = (stall == 0);
      ia.req_valid  = 1'b1;
      ia.req_write  = wr;
      ia.req_addr   = a;
      ia.req_wdata  = wd;
      ia.req_funct3 = f3;
      @(posedge clk); #1;
      ia.req_valid  = 1'b0;
      ia.req_write  = 1'($urandom);
      ia.req_addr   = $urandom;
      ia.req_wdata  = $urandom;
      ia.req_funct3 = 3'($urandom);
      if (stall > 0) begin
         repeat (stall + 2) @(posedge clk);
         #1;
         ia.resp_ready = 1'b1;
      end
      guard = 0;
      while ((q0.size() != 0 || q1.size() != 0) && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         errors++;
         $display("FAIL timeout_resp: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
      end
   endtask

   // Store whose LATENCY-2 copy is still in WAIT when reset hits; LATENCY-1 copy already wrote
   task automatic reset_during_wait(input logic [31:0] a, input logic [31:0] wd);
      logic [7:0] keep [4];
      wait_ready();
      for (int k = 0; k < 4; k++) keep[k] = get_byte(0, a + 32'(k));
      q0.push_back(model(0, 1'b1, a, wd, 3'b010));
      q1.push_back(model(1, 1'b1, a, wd, 3'b010));
      ia.resp_ready = 1'b0;
      ia.req_valid  = 1'b1;
      ia.req_write  = 1'b1;
      ia.req_addr   = a;
      ia.req_wdata  = wd;
      ia.req_funct3 = 3'b010;
      @(posedge clk); #1;
      ia.req_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async_valid_a", {31'd0, ia.resp_valid}, 32'd0);
      chk("rst_async_valid_b", {31'd0, ib.resp_valid}, 32'd0);
      chk("rst_async_rdata_b", ib.resp_rdata, 32'd0);
      chk("rst_async_err_b", {31'd0, ib.resp_err}, 32'd0);
      q0.delete();
      q1.delete();
      for (int k = 0; k < 4; k++) put_byte(0, a + 32'(k), keep[k]);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      ia.resp_ready = 1'b1;
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  f3;
      bit          wr;
      errors = 0;
      checks = 0;
      cyc    = 0;
      ia.req_valid  = 1'b0;
      ia.req_write  = 1'b0;
      ia.req_addr   = 32'd0;
      ia.req_wdata  = 32'd0;
      ia.req_funct3 = 3'd0;
      ia.resp_ready = 1'b1;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", {31'd0, ia.resp_valid}, 32'd0);
      chk("reset_rdata", ia.resp_rdata, 32'd0);
      chk("reset_err", {31'd0, ia.resp_err}, 32'd0);
      chk("reset_ready", {31'd0, ia.req_ready}, 32'd1);
      reset = 1'b0;
      @(posedge clk); #1;

      issue(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0);
      issue(1'b0, 32'h10, 32'h0, 3'b010, 0);
      issue(1'b1, 32'h13, 32'h0000_0080, 3'b000, 0);
      issue(1'b0, 32'h13, 32'h0, 3'b000, 0);
      issue(1'b0, 32'h13, 32'h0, 3'b100, 0);
      issue(1'b0, 32'h10, 32'h0, 3'b010, 0);
      issue(1'b1, 32'h12, 32'h0000_1234, 3'b001, 0);
      issue(1'b0, 32'h12, 32'h0, 3'b001, 0);
      issue(1'b0, 32'h11, 32'h0, 3'b101, 0);
      issue(1'b0, 32'h10, 32'h0, 3'b010, 5);
      issue(1'b1, 32'h20, 32'h0, 3'b010, 0);
      reset_during_wait(32'h20, 32'hFFFF_FFFF);
      issue(1'b0, 32'h20, 32'h0, 3'b010, 0);
      issue(1'b1, 32'h0000_1000, 32'h5555_AAAA, 3'b010, 0);
      issue(1'b0, 32'h10, 32'h0, 3'b011, 0);
      issue(1'b1, 32'h14, 32'h77, 3'b100, 0);
      issue(1'b1, 32'h12, 32'h99, 3'b010, 0);
      issue(1'b1, 32'hFFC, 32'hCAFE_F00D, 3'b010, 0);
      issue(1'b0, 32'hFFE, 32'h0, 3'b001, 0);
      issue(1'b0, 32'h10, 32'h0, 3'b010, 0);

      for (int i = 0; i < 16; i++) issue(1'b1, 32'(4*i), $urandom, 3'b010, 0);
      for (int i = 0; i < 150; i++) begin
         a  = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 15) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
         f3 = 3'($urandom_range(0, 7));
         wr = 1'($urandom_range(0, 2) == 0);
         issue(wr, a, $urandom, f3, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
